// File: rtl/core_pkg.sv
// Shared encodings and defaults for the core pipeline stages.
package core_pkg;

   localparam int DATA_W_DEF    = 32;
   localparam int MUL_W_DEF     = 64;
   localparam int MAX_OUTST_DEF = 2;

   typedef enum logic [2:0] {
      LD_W  = 3'd0,
      LD_B  = 3'd1,
      LD_BU = 3'd2,
      LD_H  = 3'd3,
      LD_HU = 3'd4
   } ld_op_e;

   // Counter must represent 0..max_outst inclusive.
   function automatic int cnt_width(input int max_outst);
      return (max_outst < 1) ? 1 : $clog2(max_outst + 1);
   endfunction

endpackage

// File: rtl/load_align.sv
// Sub-word load alignment: picks the addressed byte/half and sign/zero-extends it.
module load_align
   import core_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        addr,
   input  logic [2:0]        ld_op,
   output logic [DATA_W-1:0] data
);

   logic [7:0]  b8;
   logic [15:0] h16;

   always_comb begin
      b8  = 8'(rdata >> {addr, 3'b000});
      h16 = 16'(rdata >> {addr[1], 4'b0000});
      case (ld_op_e'(ld_op))
         LD_B:    data = {{(DATA_W-8){b8[7]}}, b8};
         LD_BU:   data = {{(DATA_W-8){1'b0}}, b8};
         LD_H:    data = {{(DATA_W-16){h16[15]}}, h16};
         LD_HU:   data = {{(DATA_W-16){1'b0}}, h16};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage_async.sv
// MEM pipeline stage: waits on split data_sram responses, aligns loads, selects
// the multiplier half and drops responses owed to flushed loads.
module mem_stage_async
   import core_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MUL_W     = MUL_W_DEF,
   parameter int MAX_OUTST = MAX_OUTST_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              es2ms_valid,
   output logic              ms_allowin,
   output logic              ms2ws_valid,
   input  logic              ws_allowin,
   input  logic              ms_flush,
   input  logic [31:0]       es_pc,
   input  logic [DATA_W-1:0] es_alu_result,
   input  logic              es_mem_req,
   input  logic [2:0]        es_ld_op,
   input  logic              es_res_from_mul,
   input  logic              es_mul_hi,
   input  logic [MUL_W-1:0]  es_mul_result,
   input  logic              es_gr_we,
   input  logic [4:0]        es_dest,
   input  logic              data_sram_data_ok,
   input  logic [DATA_W-1:0] data_sram_rdata,
   output logic [31:0]       ms_pc,
   output logic              ms_gr_we,
   output logic [4:0]        ms_dest,
   output logic [DATA_W-1:0] ms_final_result,
   output logic              ms_fwd_valid,
   output logic              ms_load_wait
);

   localparam int CNT_W = cnt_width(MAX_OUTST);
   localparam logic [CNT_W:0] CNT_MAX = MAX_OUTST[CNT_W:0];

   logic              ms_valid;
   logic [DATA_W-1:0] alu_r;
   logic              mem_req_r;
   logic [2:0]        ld_op_r;
   logic              res_from_mul_r;
   logic              mul_hi_r;
   logic [DATA_W-1:0] rdata_buf;
   logic              rdata_buf_v;
   logic [CNT_W-1:0]  cancel_cnt;
   logic [CNT_W:0]    cnt_sum;

   logic              resp_live;
   logic              ms_ready_go;
   logic              leave;
   logic              cnt_inc_ms;
   logic              cnt_inc_es;
   logic              cnt_dec;
   logic [DATA_W-1:0] ld_raw;
   logic [DATA_W-1:0] ld_data;
   logic [DATA_W-1:0] mul_sel;

   // A response only belongs to the current load when nothing is owed to flushed ones.
   assign resp_live    = data_sram_data_ok && (cancel_cnt == '0);
   assign ms_ready_go  = !mem_req_r || rdata_buf_v || resp_live;
   assign ms_allowin   = !ms_valid || (ms_ready_go && ws_allowin);
   assign ms2ws_valid  = ms_valid && ms_ready_go;
   assign leave        = ms2ws_valid && ws_allowin;
   assign ms_fwd_valid = ms2ws_valid && ms_gr_we;
   assign ms_load_wait = ms_valid && !ms_ready_go;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ms_valid       <= 1'b0;
         ms_pc          <= '0;
         alu_r          <= '0;
         mem_req_r      <= 1'b0;
         ld_op_r        <= '0;
         res_from_mul_r <= 1'b0;
         mul_hi_r       <= 1'b0;
         ms_gr_we       <= 1'b0;
         ms_dest        <= '0;
      end else begin
         if (ms_flush) begin
            ms_valid <= 1'b0;
         end else if (ms_allowin) begin
            ms_valid <= es2ms_valid;
         end
         if (es2ms_valid && ms_allowin) begin
            ms_pc          <= es_pc;
            alu_r          <= es_alu_result;
            mem_req_r      <= es_mem_req;
            ld_op_r        <= es_ld_op;
            res_from_mul_r <= es_res_from_mul;
            mul_hi_r       <= es_mul_hi;
            ms_gr_we       <= es_gr_we;
            ms_dest        <= es_dest;
         end
      end
   end

   // Hold a response that arrived while WB was stalled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_buf_v <= 1'b0;
         rdata_buf   <= '0;
      end else if (ms_flush || leave) begin
         rdata_buf_v <= 1'b0;
      end else if (ms_valid && mem_req_r && !rdata_buf_v && resp_live) begin
         rdata_buf_v <= 1'b1;
         rdata_buf   <= data_sram_rdata;
      end
   end

   assign cnt_inc_ms = ms_flush && ms_valid && mem_req_r && !rdata_buf_v && !resp_live;
   assign cnt_inc_es = ms_flush && es2ms_valid && es_mem_req;
   assign cnt_dec    = data_sram_data_ok && (cancel_cnt != '0);

   always_comb begin
      cnt_sum = {1'b0, cancel_cnt} + {{CNT_W{1'b0}}, cnt_inc_ms}
              + {{CNT_W{1'b0}}, cnt_inc_es} - {{CNT_W{1'b0}}, cnt_dec};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cancel_cnt <= '0;
      end else if (cnt_sum > CNT_MAX) begin
         cancel_cnt <= CNT_MAX[CNT_W-1:0];
      end else begin
         cancel_cnt <= cnt_sum[CNT_W-1:0];
      end
   end

   a_cancel_overflow: assert property (@(posedge clk) disable iff (reset) cnt_sum <= CNT_MAX);

   assign ld_raw  = rdata_buf_v ? rdata_buf : data_sram_rdata;
   assign mul_sel = mul_hi_r ? es_mul_result[MUL_W-1:DATA_W] : es_mul_result[DATA_W-1:0];

   load_align #(.DATA_W(DATA_W)) u_load_align (
      .rdata (ld_raw),
      .addr  (alu_r[1:0]),
      .ld_op (ld_op_r),
      .data  (ld_data)
   );

   assign ms_final_result = mem_req_r      ? ld_data :
                            res_from_mul_r ? mul_sel : alu_r;

endmodule

// File: tb/tb_mem_stage_async.sv
// Randomized bench for mem_stage_async against a transaction-level stage/SRAM model.
module tb_mem_stage_async;

   logic        clk = 1'b0;
   logic        reset;
   logic        es2ms_valid, ms_allowin, ms2ws_valid, ws_allowin, ms_flush;
   logic [31:0] es_pc, es_alu_result;
   logic        es_mem_req;
   logic [2:0]  es_ld_op;
   logic        es_res_from_mul, es_mul_hi;
   logic [63:0] es_mul_result;
   logic        es_gr_we;
   logic [4:0]  es_dest;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic [31:0] ms_pc;
   logic        ms_gr_we;
   logic [4:0]  ms_dest;
   logic [31:0] ms_final_result;
   logic        ms_fwd_valid, ms_load_wait;

   always #5 clk = ~clk;

   mem_stage_async #(.DATA_W(32), .MUL_W(64), .MAX_OUTST(2)) dut (
      .clk(clk), .reset(reset),
      .es2ms_valid(es2ms_valid), .ms_allowin(ms_allowin),
      .ms2ws_valid(ms2ws_valid), .ws_allowin(ws_allowin), .ms_flush(ms_flush),
      .es_pc(es_pc), .es_alu_result(es_alu_result), .es_mem_req(es_mem_req),
      .es_ld_op(es_ld_op), .es_res_from_mul(es_res_from_mul), .es_mul_hi(es_mul_hi),
      .es_mul_result(es_mul_result), .es_gr_we(es_gr_we), .es_dest(es_dest),
      .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
      .ms_pc(ms_pc), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest),
      .ms_final_result(ms_final_result), .ms_fwd_valid(ms_fwd_valid),
      .ms_load_wait(ms_load_wait)
   );

   typedef struct {
      logic        v;
      int          id;
      logic [31:0] pc;
      logic [31:0] alu;
      logic        load;
      logic [2:0]  op;
      logic        mul;
      logic        hi;
      logic [63:0] prod;
      logic        we;
      logic [4:0]  dest;
      logic        seen;
      logic [31:0] rdat;
   } ins_t;

   typedef struct {
      int          id;
      logic [31:0] data;
      int          due;
      logic        killed;
   } rsp_t;

   ins_t        slot, exe, nxt;
   rsp_t        q[$];
   int          now, next_id, total, bad, wait_cnt;
   logic        want_new, flush_in, ws_in, stray_in;
   int          lat_in;
   logic [31:0] dat_in, last_res;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, now);
      end
   endtask

   function automatic ins_t mk(input logic [31:0] pc, input logic [31:0] alu, input logic load,
                               input logic [2:0] op, input logic mul, input logic hi,
                               input logic [63:0] prod, input logic we, input logic [4:0] dest);
      ins_t s;
      s = '{default: '0};
      s.pc = pc; s.alu = alu; s.load = load; s.op = op; s.mul = mul; s.hi = hi;
      s.prod = prod; s.we = we; s.dest = dest;
      return s;
   endfunction

   // Architectural result of an instruction given the word returned by memory.
   function automatic logic [31:0] exp_res(input ins_t s, input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(d >> (8 * s.alu[1:0]));
      h = 16'(d >> (16 * s.alu[1]));
      if (s.load) begin
         case (s.op)
            3'd1:    return 32'(int'(b) - (b[7] ? 256 : 0));
            3'd2:    return 32'(int'(b));
            3'd3:    return 32'(int'(h) - (h[15] ? 65536 : 0));
            3'd4:    return 32'(int'(h));
            default: return d;
         endcase
      end
      if (s.mul) return s.hi ? s.prod[63:32] : s.prod[31:0];
      return s.alu;
   endfunction

   task automatic cycle();
      logic popped, resp_now, exp_ready, exp_allow;
      logic [31:0] d;
      rsp_t r;
      int k;
      if (!exe.v && want_new) begin
         exe = nxt; exe.v = 1'b1; exe.id = next_id; exe.seen = 1'b0; next_id++;
         if (exe.load) q.push_back('{id: exe.id, data: dat_in, due: now + lat_in, killed: 1'b0});
      end
      es2ms_valid = exe.v;       es_pc = exe.pc;          es_alu_result = exe.alu;
      es_mem_req = exe.v && exe.load;                      es_ld_op = exe.op;
      es_res_from_mul = exe.mul; es_mul_hi = exe.hi;       es_gr_we = exe.we;
      es_dest = exe.dest;        ms_flush = flush_in;      ws_allowin = ws_in;
      es_mul_result = slot.v ? slot.prod : {$urandom, $urandom};
      popped = 1'b0;
      if (q.size() > 0 && q[0].due <= now && (q[0].killed || (slot.v && q[0].id == slot.id))) begin
         popped = 1'b1;
         data_sram_data_ok = 1'b1;
         data_sram_rdata = q[0].data;
      end else begin
         data_sram_data_ok = stray_in;
         data_sram_rdata = $urandom;
      end
      resp_now  = popped && !q[0].killed;
      exp_ready = slot.v && (!slot.load || slot.seen || resp_now);
      exp_allow = !slot.v || (exp_ready && ws_in);
      d = slot.seen ? slot.rdat : data_sram_rdata;
      #4;
      chk_eq("allowin", ms_allowin, exp_allow);
      chk_eq("ms2ws_valid", ms2ws_valid, exp_ready);
      chk_eq("load_wait", ms_load_wait, slot.v && !exp_ready);
      if (ms_load_wait) wait_cnt++;
      if (exp_ready) begin
         chk_eq("result", ms_final_result, exp_res(slot, d));
         chk_eq("pc", ms_pc, slot.pc);
         chk_eq("we_dest", {ms_gr_we, ms_dest}, {slot.we, slot.dest});
         chk_eq("fwd_valid", ms_fwd_valid, slot.we);
         if (ws_in) last_res = ms_final_result;
      end
      @(posedge clk);
      #1;
      now++;
      if (popped) begin
         r = q.pop_front();
         if (!r.killed) begin
            slot.seen = 1'b1;
            slot.rdat = r.data;
         end
      end
      if (flush_in) begin
         foreach (q[i])
            if ((slot.v && q[i].id == slot.id) || (exe.v && q[i].id == exe.id)) q[i].killed = 1'b1;
         slot.v = 1'b0;
         exe.v = 1'b0;
      end else begin
         if (exp_ready && ws_in) slot.v = 1'b0;
         if (exp_allow && exe.v) begin
            slot = exe;
            exe.v = 1'b0;
         end
      end
      k = 0;
      foreach (q[i]) if (q[i].killed) k++;
      chk_eq("cancel_cnt", 64'(dut.cancel_cnt), 64'(k));
   endtask

   task automatic issue(input ins_t s, input int lat, input logic [31:0] dat);
      nxt = s; lat_in = lat; dat_in = dat; want_new = 1'b1;
      cycle();
      want_new = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      total = 0; bad = 0; now = 0; next_id = 1; wait_cnt = 0; last_res = '0;
      slot = '{default: '0}; exe = '{default: '0}; nxt = '{default: '0};
      want_new = 0; flush_in = 0; ws_in = 1; stray_in = 0; lat_in = 1; dat_in = '0;
      reset = 1'b1;
      es2ms_valid = 0; es_pc = '0; es_alu_result = '0; es_mem_req = 0; es_ld_op = '0;
      es_res_from_mul = 0; es_mul_hi = 0; es_mul_result = '0; es_gr_we = 0; es_dest = '0;
      ws_allowin = 1; ms_flush = 0; data_sram_data_ok = 0; data_sram_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_eq("rst_ms2ws_valid", ms2ws_valid, 0);
      chk_eq("rst_allowin", ms_allowin, 1);
      chk_eq("rst_result", ms_final_result, 0);
      chk_eq("rst_pc", ms_pc, 0);
      chk_eq("rst_load_wait", ms_load_wait, 0);
      chk_eq("rst_fwd", ms_fwd_valid, 0);
      chk_eq("rst_cancel_cnt", 64'(dut.cancel_cnt), 0);
      @(posedge clk);
      #1 reset = 1'b0;

      // ALU op flows straight through
      issue(mk(32'h1c00_0000, 32'h5, 0, 0, 0, 0, 64'h0, 1, 5'd3), 1, 0);
      run(2);
      chk_eq("t1_alu", last_res, 32'h5);

      // ld.b at byte 3, response 3 cycles after entering MEM
      wait_cnt = 0;
      issue(mk(32'h1c00_0004, 32'h1000_0003, 1, 3'd1, 0, 0, 64'h0, 1, 5'd4), 4, 32'h80FF_0000);
      run(6);
      chk_eq("t2_ldb", last_res, 32'hFFFF_FF80);
      chk_eq("t2_wait_cycles", 64'(wait_cnt), 3);
      issue(mk(32'h1c00_0008, 32'h1000_0002, 1, 3'd4, 0, 0, 64'h0, 1, 5'd5), 4, 32'h80FF_0000);
      run(6);
      chk_eq("t2_ldhu", last_res, 32'h0000_80FF);

      // response arrives while WB stalls, held in the buffer
      ws_in = 1'b0;
      issue(mk(32'h1c00_000c, 32'h2000_0004, 1, 3'd0, 0, 0, 64'h0, 1, 5'd6), 2, 32'hCAFE_BABE);
      run(3);
      ws_in = 1'b1;
      run(2);
      chk_eq("t3_buffered", last_res, 32'hCAFE_BABE);
      chk_eq("t3_buf_clear", 64'(dut.rdata_buf_v), 0);

      // flushed load's response is dropped, next load gets its own data
      issue(mk(32'h1c00_0010, 32'h1000_0000, 1, 3'd0, 0, 0, 64'h0, 1, 5'd7), 3, 32'h0000_DEAD);
      flush_in = 1'b1;
      cycle();
      flush_in = 1'b0;
      chk_eq("t4_cnt_one", 64'(dut.cancel_cnt), 1);
      issue(mk(32'h1c00_0014, 32'h1000_0000, 1, 3'd0, 0, 0, 64'h0, 1, 5'd8), 6, 32'h0000_1234);
      run(8);
      chk_eq("t4_own_data", last_res, 32'h0000_1234);
      chk_eq("t4_cnt_zero", 64'(dut.cancel_cnt), 0);

      // multiplier half select
      issue(mk(32'h1c00_0018, 32'h0, 0, 0, 1, 1, 64'h0000_0002_0000_0003, 1, 5'd9), 1, 0);
      run(1);
      chk_eq("t5_mul_hi", last_res, 32'h2);
      issue(mk(32'h1c00_001c, 32'h0, 0, 0, 1, 0, 64'h0000_0002_0000_0003, 1, 5'd9), 1, 0);
      run(1);
      chk_eq("t5_mul_lo", last_res, 32'h3);

      // async reset in the middle of a pending load with a non-zero cancel count
      issue(mk(32'h1c00_0020, 32'h1000_0000, 1, 3'd0, 0, 0, 64'h0, 1, 5'd1), 20, 32'h1111_1111);
      flush_in = 1'b1;
      cycle();
      flush_in = 1'b0;
      issue(mk(32'h1c00_0024, 32'h1000_0000, 1, 3'd0, 0, 0, 64'h0, 1, 5'd2), 20, 32'h2222_2222);
      cycle();
      #2 reset = 1'b1;
      es2ms_valid = 1'b0;
      es_mem_req = 1'b0;
      #1;
      chk_eq("t6_ms_valid", 64'(dut.ms_valid), 0);
      chk_eq("t6_ms2ws_valid", ms2ws_valid, 0);
      chk_eq("t6_cancel_cnt", 64'(dut.cancel_cnt), 0);
      chk_eq("t6_load_wait", ms_load_wait, 0);
      q.delete();
      slot.v = 1'b0;
      exe.v = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      stray_in = 1'b1;
      cycle();
      stray_in = 1'b0;
      run(2);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         want_new = ($urandom_range(0, 2) != 0);
         nxt = mk($urandom, $urandom, (q.size() < 2) && ($urandom_range(0, 1) == 1),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  {$urandom, $urandom}, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
         lat_in   = $urandom_range(1, 6);
         dat_in   = $urandom;
         flush_in = ($urandom_range(0, 15) == 0);
         ws_in    = ($urandom_range(0, 3) != 0);
         cycle();
      end
      want_new = 1'b0;
      flush_in = 1'b0;
      ws_in = 1'b1;
      run(40);
      chk_eq("drain_ms_valid", 64'(dut.ms_valid), 0);
      chk_eq("drain_cancel_cnt", 64'(dut.cancel_cnt), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
